stage_mem: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline, between the execute stage and the write-back stage. It turns execute-stage load/store requests into single transfers on the data Wishbone master port. It aligns and sign-extends load data, generates store byte selects, and detects misaligned load/store addresses. It registers the results (`mem_d_o`, `mem_addr_o`, misalignment flags) that the write-back stage consumes, and holds the pipeline with `stall_o` while a bus transfer is outstanding.

---
 rtl/core_pkg.sv | 19 +
 rtl/stage_mem_if.sv | 14 +
 rtl/mem_align.sv | 56 +++++
 rtl/stage_mem.sv | 116 +++++++++++
 tb/tb_stage_mem.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: memory funct3 encodings and the
// memory-stage FSM state type.
package core_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } mem_state_e;

endpackage

// File: rtl/stage_mem_if.sv
// Data-side Wishbone master bundle between the memory stage and the bus.
interface stage_mem_if;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;

  modport master (output addr, dat_w, sel, cyc, stb, we, input dat_r, ack);
  modport slave  (input addr, dat_w, sel, cyc, stb, we, output dat_r, ack);
endinterface

// File: rtl/mem_align.sv
// Combinational alignment helper: misaligned check, store lane/byte-select
// generation and load lane extraction with sign/zero extension.
module mem_align
  import core_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] st_d,
  output logic        misaligned,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0]        shifted;
  logic signed [7:0]  lb_s;
  logic signed [15:0] lh_s;

  always_comb begin
    misaligned = 1'b0;
    sel        = 4'b1111;
    wdat       = st_d;
    case (size)
      2'b00: begin
        sel  = 4'b0001 << addr[1:0];
        wdat = {4{st_d[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        sel        = 4'b0011 << addr[1:0];
        wdat       = {2{st_d[15:0]}};
      end
      default: misaligned = |addr[1:0];
    endcase
  end

  // Lane select uses the address latched at request time.
  assign shifted = ld_raw >> {ld_lane, 3'b000};
  assign lb_s    = shifted[7:0];
  assign lh_s    = shifted[15:0];

  always_comb begin
    ld_data = ld_raw;
    case (ld_funct3)
      F3_LB:   ld_data = 32'(lb_s);
      F3_LH:   ld_data = 32'(lh_s);
      F3_LBU:  ld_data = {24'd0, shifted[7:0]};
      F3_LHU:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// RV32I memory-access stage: issues one Wishbone transfer per load/store,
// stalls upstream while it is outstanding, and registers results for write-back.
module stage_mem
  import core_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        is_ld_mem_i,
  input  logic        is_st_mem_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] st_d_i,
  input  logic        flush_i,
  stage_mem_if.master dwbm,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        stall_o
);

  mem_state_e  state, state_nxt;
  logic        misaligned;
  logic [3:0]  sel_req;
  logic [31:0] wdat_req;
  logic [31:0] ld_data;
  logic [31:0] addr_p1;
  logic [31:0] dat_p1;
  logic [3:0]  sel_p1;
  logic [2:0]  f3_p1;
  logic        cyc_p1;
  logic        we_p1;
  logic        is_mem;
  logic        in_bus;
  logic        ack_bus;
  logic        start;

  mem_align u_align (
    .size       (funct3_i[1:0]),
    .addr       (alu_d_i),
    .st_d       (st_d_i),
    .misaligned (misaligned),
    .sel        (sel_req),
    .wdat       (wdat_req),
    .ld_funct3  (f3_p1),
    .ld_lane    (addr_p1[1:0]),
    .ld_raw     (dwbm.dat_r),
    .ld_data    (ld_data)
  );

  assign is_mem  = is_ld_mem_i | is_st_mem_i;
  assign in_bus  = (state == ST_BUS);
  assign ack_bus = in_bus & dwbm.ack;
  assign start   = valid_i & is_mem & ~misaligned & ~flush_i & (state == ST_IDLE);
  assign stall_o = start | (in_bus & ~dwbm.ack);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A flush during BUS does not abort: the transfer always runs to ack.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = ST_BUS;
      ST_BUS:  if (dwbm.ack) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Request stage -> bus stage: outputs frozen from start until ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_p1  <= 1'b0;
      we_p1   <= 1'b0;
      addr_p1 <= '0;
      sel_p1  <= '0;
      dat_p1  <= '0;
      f3_p1   <= '0;
    end else if (start) begin
      cyc_p1  <= 1'b1;
      we_p1   <= is_st_mem_i;
      addr_p1 <= alu_d_i;
      sel_p1  <= sel_req;
      dat_p1  <= wdat_req;
      f3_p1   <= funct3_i;
    end else if (ack_bus) begin
      cyc_p1  <= 1'b0;
    end
  end

  assign dwbm.addr  = {addr_p1[31:2], 2'b00};
  assign dwbm.dat_w = dat_p1;
  assign dwbm.sel   = sel_p1;
  assign dwbm.cyc   = cyc_p1;
  assign dwbm.stb   = cyc_p1;
  assign dwbm.we    = we_p1;

  // Bus stage -> write-back registers, advanced whenever the pipe moves.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_d_o         <= '0;
      mem_addr_o      <= '0;
      e_ld_addr_mis_o <= 1'b0;
      e_st_addr_mis_o <= 1'b0;
    end else if (!stall_o) begin
      mem_addr_o      <= in_bus ? addr_p1 : alu_d_i;
      mem_d_o         <= ack_bus ? ld_data : '0;
      e_ld_addr_mis_o <= valid_i & is_ld_mem_i & misaligned & ~flush_i;
      e_st_addr_mis_o <= valid_i & is_st_mem_i & misaligned & ~flush_i;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: directed scenarios then random
// load/store traffic against a byte-level reference model.
module tb_stage_mem;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        is_ld_mem_i = 1'b0;
  logic        is_st_mem_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] alu_d_i = '0;
  logic [31:0] st_d_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] mem_d_o;
  logic [31:0] mem_addr_o;
  logic        e_ld_addr_mis_o;
  logic        e_st_addr_mis_o;
  logic        stall_o;

  int n_chk = 0;
  int n_fail = 0;

  stage_mem_if dwbm ();

  stage_mem dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .valid_i         (valid_i),
    .is_ld_mem_i     (is_ld_mem_i),
    .is_st_mem_i     (is_st_mem_i),
    .funct3_i        (funct3_i),
    .alu_d_i         (alu_d_i),
    .st_d_i          (st_d_i),
    .flush_i         (flush_i),
    .dwbm            (dwbm.master),
    .mem_d_o         (mem_d_o),
    .mem_addr_o      (mem_addr_o),
    .e_ld_addr_mis_o (e_ld_addr_mis_o),
    .e_st_addr_mis_o (e_st_addr_mis_o),
    .stall_o         (stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes from the size field.
  function automatic int unsigned nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_sel(input logic [2:0] f3, input logic [31:0] a);
    int unsigned m;
    m = ((1 << nbytes(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdat(input logic [2:0] f3, input logic [31:0] d);
    case (nbytes(f3))
      1: return (d % 256) * 32'h0101_0101;
      2: return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
    int unsigned v;
    int b, h;
    v = d / (32'd1 << (8 * (a % 4)));
    b = int'(v % 256);
    h = int'(v % 65536);
    case (f3)
      3'b000:  return 32'((b >= 128) ? b - 256 : b);
      3'b001:  return 32'((h >= 32768) ? h - 65536 : h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return d;
    endcase
  endfunction

  // One instruction through the stage; entered and left at 1ns after a rising edge.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int waits,
                        input bit fl, input bit fl_bus);
    bit mis, go;
    logic [3:0]  s;
    logic [31:0] wd;
    mis = (ld || st) && model_mis(f3, addr);
    go  = (ld || st) && !mis && !fl;
    s   = model_sel(f3, addr);
    wd  = model_wdat(f3, sd);
    valid_i = 1'b1; is_ld_mem_i = ld; is_st_mem_i = st; funct3_i = f3;
    alu_d_i = addr; st_d_i = sd; flush_i = fl;
    dwbm.ack = 1'b0; dwbm.dat_r = $urandom;
    @(negedge clk_i);
    chk("stall_req", 32'(stall_o), 32'(go));
    if (go) begin
      @(posedge clk_i); #1;
      if (fl_bus) flush_i = 1'b1;
      for (int w = 0; w <= waits; w++) begin
        if (w == waits) begin
          dwbm.ack = 1'b1; dwbm.dat_r = rd;
        end
        @(negedge clk_i);
        chk("stall_bus", 32'(stall_o), 32'(w != waits));
        chk("cyc", 32'(dwbm.cyc), 32'd1);
        chk("stb", 32'(dwbm.stb), 32'd1);
        chk("we", 32'(dwbm.we), 32'(st));
        chk("addr", dwbm.addr, {addr[31:2], 2'b00});
        chk("sel", 32'(dwbm.sel), 32'(s));
        chk("dat", dwbm.dat_w, wd);
        @(posedge clk_i); #1;
      end
      dwbm.ack = 1'b0;
      chk("cyc_end", 32'(dwbm.cyc), 32'd0);
      chk("stb_end", 32'(dwbm.stb), 32'd0);
      chk("mem_d", mem_d_o, model_load(f3, addr, rd));
      chk("mem_addr", mem_addr_o, addr);
      chk("e_ld", 32'(e_ld_addr_mis_o), 32'd0);
      chk("e_st", 32'(e_st_addr_mis_o), 32'd0);
    end else begin
      @(posedge clk_i); #1;
      chk("cyc_none", 32'(dwbm.cyc), 32'd0);
      chk("mem_addr_nb", mem_addr_o, addr);
      chk("mem_d_nb", mem_d_o, 32'd0);
      chk("e_ld_nb", 32'(e_ld_addr_mis_o), 32'(ld && mis && !fl));
      chk("e_st_nb", 32'(e_st_addr_mis_o), 32'(st && mis && !fl));
    end
    valid_i = 1'b0; is_ld_mem_i = 1'b0; is_st_mem_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, 32'(dwbm.cyc), 32'd0);
    chk({tag, "_stb"}, 32'(dwbm.stb), 32'd0);
    chk({tag, "_we"}, 32'(dwbm.we), 32'd0);
    chk({tag, "_addr"}, dwbm.addr, 32'd0);
    chk({tag, "_sel"}, 32'(dwbm.sel), 32'd0);
    chk({tag, "_dat"}, dwbm.dat_w, 32'd0);
    chk({tag, "_mem_d"}, mem_d_o, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_e_ld"}, 32'(e_ld_addr_mis_o), 32'd0);
    chk({tag, "_e_st"}, 32'(e_st_addr_mis_o), 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    bit ld, st;
    int unsigned kind;
    logic [2:0] f3;
    dwbm.ack = 1'b0;
    dwbm.dat_r = '0;

    #12;
    chk_all_zero("reset");
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Directed scenarios
    run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0, 0);
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 0, 0, 0);
    run_op(0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 32'h0, 0, 0, 0);
    run_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0, 0);
    run_op(0, 1, 3'b001, 32'h201, 32'h5555_AAAA, 32'h0, 0, 0, 0);
    run_op(0, 0, 3'b000, 32'h0000_0ABC, 32'h0, 32'h0, 0, 0, 0);
    run_op(1, 0, 3'b001, 32'h406, 32'h0, 32'h8001_7FFF, 3, 0, 0);
    run_op(1, 0, 3'b101, 32'h406, 32'h0, 32'h8001_7FFF, 1, 0, 0);
    run_op(1, 0, 3'b010, 32'h500, 32'h0, 32'h1111_2222, 0, 1, 0);
    run_op(1, 0, 3'b010, 32'h504, 32'h0, 32'h3333_4444, 2, 0, 1);
    run_op(0, 1, 3'b000, 32'h601, 32'hFFFF_FF5A, 32'h0, 1, 0, 0);

    // Reset in the middle of a transfer
    valid_i = 1'b1; is_ld_mem_i = 1'b1; funct3_i = 3'b010; alu_d_i = 32'h300;
    @(posedge clk_i); #1;
    chk("rst_pre_cyc", 32'(dwbm.cyc), 32'd1);
    valid_i = 1'b0; is_ld_mem_i = 1'b0;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    run_op(1, 0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      ld = (kind <= 1);
      st = (kind == 2 || kind == 3);
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      run_op(ld, st, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
